// File: rtl/mem_store_pkg.sv
`default_nettype none
// ============================================================================
// mem_store_pkg : store/load size encodings, store FSM states, lane helpers
// Rev 1.0 : initial release
// ============================================================================
package mem_store_pkg;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    FAULT = 3'd4
  } store_state_t;

  // The reserved code 2'b10 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] lane);
    case (mask)
      MASK_BYTE: is_misaligned = 1'b0;
      MASK_HALF: is_misaligned = lane[0];
      default:   is_misaligned = |lane;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [31:0] data, input logic [1:0] mask);
    case (mask)
      MASK_BYTE: replicate_store = {4{data[7:0]}};
      MASK_HALF: replicate_store = {2{data[15:0]}};
      default:   replicate_store = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_merge.sv
`default_nettype none
// ============================================================================
// store_lane_merge : places store data into its little-endian byte lanes of
//                    an existing word and reports the lanes touched.
// Rev 1.0 : initial release
// ============================================================================
module store_lane_merge
  import mem_store_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0]   i_old_word,
  input  logic [NB_DATA-1:0]   i_new_data,
  input  logic [1:0]           i_mask,
  input  logic [1:0]           i_lane,
  output logic [NB_DATA-1:0]   o_merged,
  output logic [NB_DATA/8-1:0] o_byte_en
);

  localparam int NB_LANES = NB_DATA / 8;

  logic [NB_LANES-1:0] w_lane_en;

  always_comb begin
    w_lane_en = '0;
    case (i_mask)
      MASK_BYTE: w_lane_en[i_lane] = 1'b1;
      MASK_HALF: w_lane_en[{i_lane[1], 1'b0} +: 2] = 2'b11;
      default:   w_lane_en = '1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB_LANES; gi++) begin : g_lane
      logic [7:0] w_src;

      // Sub-word data always comes from the low bits of the source register.
      always_comb begin
        case (i_mask)
          MASK_BYTE: w_src = i_new_data[7:0];
          MASK_HALF: w_src = i_new_data[8*(gi%2) +: 8];
          default:   w_src = i_new_data[8*gi +: 8];
        endcase
      end

      assign o_merged[8*gi +: 8] = w_lane_en[gi] ? w_src : i_old_word[8*gi +: 8];
    end
  endgenerate

  assign o_byte_en = w_lane_en;

endmodule
`default_nettype wire

// File: rtl/store_merger.sv
`default_nettype none
// ============================================================================
// store_merger : MEM-stage SB/SH/SW engine for a word-organised data memory;
//                read-modify-write by default, single write with lane enables
//                when STORE_MERGER_BYTE_ENABLE_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
module store_merger
  import mem_store_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 12,
  parameter int NB_MASK = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_store_valid,
  output logic                 o_store_ready,
  input  logic [NB_ADDR-1:0]   i_address,
  input  logic [NB_DATA-1:0]   i_dato,
  input  logic [NB_MASK-1:0]   i_mascara,
  output logic                 o_stall,
  output logic                 o_done,
  output logic                 o_misaligned,
  output logic [NB_ADDR-3:0]   o_mem_addr,
  output logic                 o_mem_read_en,
  input  logic [NB_DATA-1:0]   i_mem_rdata,
  output logic                 o_mem_write_en,
  output logic [NB_DATA-1:0]   o_mem_wdata,
  output logic [NB_DATA/8-1:0] o_mem_byte_en
);

  localparam int NB_BE = NB_DATA / 8;

`ifdef STORE_MERGER_BYTE_ENABLE_EN
  localparam store_state_t c_sub_word_first = WRITE;
`else
  localparam store_state_t c_sub_word_first = READ;
`endif

  store_state_t r_state;
  store_state_t w_next_state;

  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_data;
  logic [NB_MASK-1:0] r_mask;

  logic               w_accept;
  logic               w_is_sub_word;
  logic [NB_DATA-1:0] w_merge_old;
  logic [NB_DATA-1:0] w_merged;
  logic [NB_BE-1:0]   w_merge_be;
  logic [NB_DATA-1:0] w_write_word;
  logic [NB_BE-1:0]   w_write_be;

  assign o_store_ready = (r_state == IDLE) && !i_reset;
  assign w_accept      = i_store_valid && o_store_ready;
  assign w_is_sub_word = (i_mascara == MASK_BYTE) || (i_mascara == MASK_HALF);

`ifdef STORE_MERGER_BYTE_ENABLE_EN
  logic w_unused_rdata;

  // Lanes outside the enables carry copies of the data; memory ignores them.
  assign w_merge_old    = replicate_store(r_data, r_mask);
  assign w_write_word   = w_merged;
  assign w_write_be     = w_merge_be;
  assign w_unused_rdata = ^i_mem_rdata;
`else
  logic [NB_DATA-1:0] r_wdata;
  logic               w_unused_be;

  assign w_merge_old  = i_mem_rdata;
  assign w_write_word = r_wdata;
  assign w_write_be   = '1;
  assign w_unused_be  = ^w_merge_be;
`endif

  store_lane_merge #(
    .NB_DATA (NB_DATA)
  ) u_lane_merge (
    .i_old_word (w_merge_old),
    .i_new_data (r_data),
    .i_mask     (r_mask),
    .i_lane     (r_addr[1:0]),
    .o_merged   (w_merged),
    .o_byte_en  (w_merge_be)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    o_stall        = 1'b1;
    o_done         = 1'b0;
    o_misaligned   = 1'b0;
    o_mem_read_en  = 1'b0;
    o_mem_write_en = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_mem_byte_en  = '0;
    case (r_state)
      IDLE: begin
        o_stall = 1'b0;
        if (w_accept) begin
          if (is_misaligned(i_mascara, i_address[1:0])) begin
            w_next_state = FAULT;
          end else if (w_is_sub_word) begin
            w_next_state = c_sub_word_first;
          end else begin
            w_next_state = WRITE;
          end
        end
      end
      READ: begin
        o_mem_read_en = 1'b1;
        o_mem_addr    = r_addr[NB_ADDR-1:2];
        w_next_state  = MERGE;
      end
      MERGE: begin
        o_mem_addr   = r_addr[NB_ADDR-1:2];
        w_next_state = WRITE;
      end
      WRITE: begin
        o_mem_write_en = 1'b1;
        o_mem_addr     = r_addr[NB_ADDR-1:2];
        o_mem_wdata    = w_write_word;
        o_mem_byte_en  = w_write_be;
        o_done         = 1'b1;
        w_next_state   = IDLE;
      end
      FAULT: begin
        o_misaligned = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
`ifndef STORE_MERGER_BYTE_ENABLE_EN
      r_wdata <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_addr  <= i_address;
        r_data  <= i_dato;
        r_mask  <= i_mascara;
`ifndef STORE_MERGER_BYTE_ENABLE_EN
        r_wdata <= i_dato;
`endif
      end
`ifndef STORE_MERGER_BYTE_ENABLE_EN
      // Memory read data is valid only in MERGE; sub-word stores overwrite here.
      if (r_state == MERGE) begin
        r_wdata <= w_merged;
      end
`endif
    end
  end

endmodule
`default_nettype wire
